uart_rx_ctrl: RTL and testbench

Sequencing and buffering controller for the UART receive path. It generates the oversampled bit-timing strobes (`o_strobe`, `o_half`) that the receive FSM consumes, and pushes each completed frame and its error flags into a receive FIFO with a valid/ready read port. It also enforces a frame watchdog that aborts a stuck receive, and keeps sticky status flags for overrun and framing faults.

---
 rtl/uart_rx_ctrl.sv | 119 +++++++++++
 tb/tb_uart_rx_ctrl.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_ctrl.sv
// UART receive-path controller: oversampled bit-timing strobes, frame watchdog,
// and a first-word-fall-through receive FIFO with sticky overrun/timeout status.
module uart_rx_ctrl #(
  parameter int Oversample = 16,
  parameter int DataLength = 8,
  parameter int FifoDepth  = 8
) (
  input  logic                         i_clk,
  input  logic                         i_rst,
  input  logic                         i_prescaler_en,
  output logic                         o_strobe,
  output logic                         o_half,
  input  logic [DataLength-1:0]        i_rx_data,
  input  logic                         i_rx_fifo_write_en,
  input  logic                         i_parity_error,
  input  logic                         i_stop_bit_error,
  output logic                         o_rx_abort,
  output logic [DataLength-1:0]        o_rd_data,
  output logic                         o_rd_err,
  output logic                         o_rd_valid,
  input  logic                         i_rd_ready,
  output logic [$clog2(FifoDepth):0]   o_fifo_count,
  output logic                         o_overrun,
  output logic                         o_timeout,
  input  logic                         i_clear_status
);

  localparam int CntW    = $clog2(Oversample);
  localparam int WdLimit = (DataLength + 4) * Oversample;
  localparam int WdW     = $clog2(WdLimit + 1);
  localparam int PtrW    = $clog2(FifoDepth);
  localparam int CountW  = PtrW + 1;

  localparam logic [CntW-1:0]   CntLast = CntW'(Oversample - 1);
  localparam logic [CntW-1:0]   CntMid  = CntW'(Oversample / 2 - 1);
  localparam logic [WdW-1:0]    WdLast  = WdW'(WdLimit - 1);
  localparam logic [CountW-1:0] CountFull = CountW'(FifoDepth);

  logic [CntW-1:0]       cnt;
  logic [WdW-1:0]        wd;
  logic [PtrW-1:0]       wptr;
  logic [PtrW-1:0]       rptr;
  logic [CountW-1:0]     count;
  logic [DataLength:0]   mem [FifoDepth];
  logic [DataLength:0]   head;
  logic                  full;
  logic                  pop;
  logic                  push_ok;
  logic                  overrun_set;

  // Bit-timing prescaler; held at zero whenever the receiver is idle.
  always_ff @(posedge i_clk) begin
    if (i_rst || !i_prescaler_en || cnt == CntLast) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + CntW'(1);
    end
  end

  assign o_strobe = i_prescaler_en && (cnt == CntLast);
  assign o_half   = i_prescaler_en && (cnt == CntMid);

  // Watchdog: abort fires on the edge where wd would step onto the limit,
  // so the pulse and the sticky flag appear together in the following cycle.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      wd         <= '0;
      o_rx_abort <= 1'b0;
      o_timeout  <= 1'b0;
    end else begin
      o_rx_abort <= 1'b0;
      if (!i_prescaler_en) begin
        wd <= '0;
      end else if (wd == WdLast) begin
        wd         <= '0;
        o_rx_abort <= 1'b1;
      end else begin
        wd <= wd + WdW'(1);
      end
      o_timeout <= (i_prescaler_en && wd == WdLast) || (o_timeout && !i_clear_status);
    end
  end

  assign full        = (count == CountFull);
  assign o_rd_valid  = (count != '0);
  assign pop         = o_rd_valid && i_rd_ready;
  assign push_ok     = i_rx_fifo_write_en && (!full || pop);
  assign overrun_set = i_rx_fifo_write_en && full && !pop;

  always_ff @(posedge i_clk) begin
    if (push_ok) begin
      mem[wptr] <= {i_parity_error | i_stop_bit_error, i_rx_data};
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      wptr      <= '0;
      rptr      <= '0;
      count     <= '0;
      o_overrun <= 1'b0;
    end else begin
      if (push_ok) wptr <= wptr + PtrW'(1);
      if (pop)     rptr <= rptr + PtrW'(1);
      case ({push_ok, pop})
        2'b10:   count <= count + CountW'(1);
        2'b01:   count <= count - CountW'(1);
        default: count <= count;
      endcase
      o_overrun <= overrun_set || (o_overrun && !i_clear_status);
    end
  end

  assign head         = mem[rptr];
  assign o_rd_data    = head[DataLength-1:0];
  assign o_rd_err     = head[DataLength];
  assign o_fifo_count = count;

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// Directed self-checking bench for uart_rx_ctrl (Oversample=16, DataLength=8, FifoDepth=8).
module tb_uart_rx_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       en = 1'b0;
  logic       strobe, half;
  logic [7:0] rx_data = 8'h00;
  logic       we = 1'b0;
  logic       perr = 1'b0;
  logic       serr = 1'b0;
  logic       abort;
  logic [7:0] rd_data;
  logic       rd_err;
  logic       rd_valid;
  logic       ready = 1'b0;
  logic [3:0] fifo_count;
  logic       overrun;
  logic       timeout;
  logic       clear = 1'b0;

  int tests = 0;
  int fails = 0;

  uart_rx_ctrl #(.Oversample(16), .DataLength(8), .FifoDepth(8)) dut (
    .i_clk(clk), .i_rst(rst), .i_prescaler_en(en), .o_strobe(strobe), .o_half(half),
    .i_rx_data(rx_data), .i_rx_fifo_write_en(we), .i_parity_error(perr),
    .i_stop_bit_error(serr), .o_rx_abort(abort), .o_rd_data(rd_data), .o_rd_err(rd_err),
    .o_rd_valid(rd_valid), .i_rd_ready(ready), .o_fifo_count(fifo_count),
    .o_overrun(overrun), .o_timeout(timeout), .i_clear_status(clear)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       we;
    logic [7:0] data;
    logic       perr;
    logic       serr;
    logic       ready;
    logic       valid;
    logic [7:0] rd;
    logic       err;
    int         count;
  } vec_t;

  vec_t tbl[8];

  task automatic chk(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; en = 1'b0; we = 1'b0; ready = 1'b0; clear = 1'b0;
    tick(); tick();
    rst = 1'b0;
  endtask

  task automatic push(input logic [7:0] d, input logic pe, input logic se, input logic rdy);
    rx_data = d; perr = pe; serr = se; we = 1'b1; ready = rdy;
    tick();
    we = 1'b0; perr = 1'b0; serr = 1'b0; ready = 1'b0;
  endtask

  initial begin
    tbl[0] = '{1'b1, 8'hA5, 1'b0, 1'b0, 1'b0, 1'b1, 8'hA5, 1'b0, 1};
    tbl[1] = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 0};
    tbl[2] = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 0};
    tbl[3] = '{1'b1, 8'h3C, 1'b0, 1'b1, 1'b0, 1'b1, 8'h3C, 1'b1, 1};
    tbl[4] = '{1'b1, 8'h3D, 1'b1, 1'b0, 1'b0, 1'b1, 8'h3C, 1'b1, 2};
    tbl[5] = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b1, 8'h3D, 1'b1, 1};
    tbl[6] = '{1'b1, 8'h7E, 1'b0, 1'b0, 1'b1, 1'b1, 8'h7E, 1'b0, 1};
    tbl[7] = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 0};

    do_reset();
    @(negedge clk);
    chk("reset_valid", int'(rd_valid), 0);
    chk("reset_count", int'(fifo_count), 0);
    chk("reset_overrun", int'(overrun), 0);
    chk("reset_timeout", int'(timeout), 0);
    chk("reset_abort", int'(abort), 0);
    chk("reset_strobe", int'(strobe), 0);
    chk("reset_half", int'(half), 0);
    tick();

    // Strobe spacing over 48 enabled cycles
    en = 1'b1;
    for (int k = 0; k < 48; k++) begin
      @(negedge clk);
      chk($sformatf("half_c%0d", k), int'(half), int'((k % 16) == 7));
      chk($sformatf("strobe_c%0d", k), int'(strobe), int'((k % 16) == 15));
      tick();
    end
    en = 1'b0;
    tick();

    // Enable dropped at cycle 20, then restarted: timing must restart from zero
    en = 1'b1;
    for (int k = 0; k < 40; k++) begin
      en = !(k >= 20 && k < 31);
      #1;
      @(negedge clk);
      if (k < 20) begin
        chk($sformatf("drop_half_c%0d", k), int'(half), int'((k % 16) == 7));
        chk($sformatf("drop_strobe_c%0d", k), int'(strobe), int'((k % 16) == 15));
      end else if (k < 31) begin
        chk($sformatf("drop_half_off_c%0d", k), int'(half), 0);
        chk($sformatf("drop_strobe_off_c%0d", k), int'(strobe), 0);
      end else begin
        chk($sformatf("restart_half_c%0d", k), int'(half), int'((k - 31) == 7));
      end
      tick();
    end
    en = 1'b0;
    tick();

    // Table: single frame, pop-while-empty, error tagging, push+pop
    for (int i = 0; i < 8; i++) begin
      we = tbl[i].we; rx_data = tbl[i].data; perr = tbl[i].perr;
      serr = tbl[i].serr; ready = tbl[i].ready;
      tick();
      we = 1'b0; perr = 1'b0; serr = 1'b0; ready = 1'b0;
      @(negedge clk);
      chk($sformatf("vec%0d_valid", i), int'(rd_valid), int'(tbl[i].valid));
      chk($sformatf("vec%0d_count", i), int'(fifo_count), tbl[i].count);
      if (tbl[i].valid) begin
        chk($sformatf("vec%0d_data", i), int'(rd_data), int'(tbl[i].rd));
        chk($sformatf("vec%0d_err", i), int'(rd_err), int'(tbl[i].err));
      end
      tick();
    end

    // Overrun: nine pushes into an eight-deep FIFO
    for (int i = 0; i < 9; i++) begin
      push(8'(i), 1'b0, 1'b0, 1'b0);
      @(negedge clk);
      chk($sformatf("fill%0d_count", i), int'(fifo_count), (i < 8) ? i + 1 : 8);
      chk($sformatf("fill%0d_overrun", i), int'(overrun), int'(i == 8));
      tick();
    end
    clear = 1'b1; tick(); clear = 1'b0;
    @(negedge clk);
    chk("clear_overrun", int'(overrun), 0);
    tick();
    clear = 1'b1;
    push(8'hEE, 1'b0, 1'b0, 1'b0);
    clear = 1'b0;
    @(negedge clk);
    chk("overrun_set_wins", int'(overrun), 1);
    chk("overrun_count", int'(fifo_count), 8);
    tick();
    clear = 1'b1; tick(); clear = 1'b0;

    // Full with simultaneous push and pop
    @(negedge clk);
    chk("full_head", int'(rd_data), 8'h00);
    tick();
    push(8'h55, 1'b0, 1'b0, 1'b1);
    @(negedge clk);
    chk("full_pushpop_count", int'(fifo_count), 8);
    chk("full_pushpop_overrun", int'(overrun), 0);
    tick();
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      chk($sformatf("drain%0d_data", i), int'(rd_data), (i < 7) ? i + 1 : 8'h55);
      chk($sformatf("drain%0d_valid", i), int'(rd_valid), 1);
      tick();
      ready = 1'b1; tick(); ready = 1'b0;
    end
    @(negedge clk);
    chk("drain_empty_valid", int'(rd_valid), 0);
    chk("drain_empty_count", int'(fifo_count), 0);
    tick();

    // Watchdog: single abort at cycle 192; clear in cycle 191 loses to the set
    do_reset();
    en = 1'b1;
    for (int k = 0; k < 200; k++) begin
      clear = (k == 191);
      @(negedge clk);
      chk($sformatf("wd_abort_c%0d", k), int'(abort), int'(k == 192));
      if (k >= 185) chk($sformatf("wd_timeout_c%0d", k), int'(timeout), int'(k >= 192));
      tick();
    end
    clear = 1'b0;
    en = 1'b0;
    tick();
    @(negedge clk);
    chk("wd_timeout_sticky", int'(timeout), 1);
    tick();

    // Second hold interrupted by reset at cycle 100
    en = 1'b1;
    for (int k = 0; k < 200; k++) begin
      rst = (k == 100);
      @(negedge clk);
      chk($sformatf("wd2_abort_c%0d", k), int'(abort), 0);
      if (k > 100) begin
        chk($sformatf("wd2_timeout_c%0d", k), int'(timeout), 0);
        chk($sformatf("wd2_overrun_c%0d", k), int'(overrun), 0);
      end
      tick();
    end
    rst = 1'b0;
    en = 1'b0;
    tick();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
